// File: rtl/fifo_rd_streamer_if.sv
// Handshake bundle between the read-side drain engine and its FIFO/stream neighbours.
// master = the streamer itself; slave = whatever drives the FIFO flags and sinks the stream.
interface fifo_rd_streamer_if #(
  parameter int P_DATA_WIDTH = 4
);
  logic                    i_enable;
  logic                    o_fifo_rd_en;
  logic                    i_fifo_empty;
  logic [P_DATA_WIDTH-1:0] i_fifo_rdata;
  logic                    o_m_valid;
  logic                    i_m_ready;
  logic [P_DATA_WIDTH-1:0] o_m_data;
  logic                    o_m_last;
  logic [1:0]              o_occupancy;

  modport master (
    input  i_enable, i_fifo_empty, i_fifo_rdata, i_m_ready,
    output o_fifo_rd_en, o_m_valid, o_m_data, o_m_last, o_occupancy
  );

  modport slave (
    output i_enable, i_fifo_empty, i_fifo_rdata, i_m_ready,
    input  o_fifo_rd_en, o_m_valid, o_m_data, o_m_last, o_occupancy
  );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Async-FIFO read-side drain: credit-gated read enable, one-cycle RAM latency absorbed
// into a 3-entry skid buffer, presented as a framed valid/ready stream.
module fifo_rd_streamer #(
  parameter int P_DATA_WIDTH = 4,
  parameter int P_PKT_LEN    = 16
) (
  input  logic               i_rclk,
  input  logic               i_rrst,
  fifo_rd_streamer_if.master bus
);

  localparam int                PKT_W   = (P_PKT_LEN > 2) ? $clog2(P_PKT_LEN) : 1;
  localparam logic [PKT_W-1:0]  PKT_MAX = PKT_W'(P_PKT_LEN - 1);
  localparam logic [PKT_W-1:0]  PKT_ONE = PKT_W'(1);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [1:0]              count_q, count_d;
  logic [1:0]              wptr_q, wptr_d;
  logic [1:0]              rptr_q, rptr_d;
  logic [PKT_W-1:0]        pkt_q, pkt_d;
  logic                    inflight_q;
  logic [P_DATA_WIDTH-1:0] mem_q [3];

  logic rd_en;
  logic push;
  logic pop;
  logic m_valid;

  // Read issue: credit counts words already buffered plus the one still in the RAM pipe.
  assign rd_en   = !i_rrst && bus.i_enable && !bus.i_fifo_empty &&
                   (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
  assign push    = inflight_q;
  assign m_valid = (count_q != 2'd0);
  assign pop     = m_valid && bus.i_m_ready;

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    pkt_d   = pkt_q;
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
      pkt_d  = (pkt_q == PKT_MAX) ? '0 : pkt_q + PKT_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Stage boundary: read accepted -> RAM data arrives next cycle and is captured at the tail.
  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst) begin
      count_q    <= 2'd0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      pkt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      pkt_q      <= pkt_d;
      inflight_q <= rd_en;
    end
  end

  always_ff @(posedge i_rclk) begin
    if (push) mem_q[wptr_q] <= bus.i_fifo_rdata;
  end

  // Storage is left unreset, so data is gated to zero while the buffer is empty.
  assign bus.o_fifo_rd_en = rd_en;
  assign bus.o_m_valid    = m_valid;
  assign bus.o_m_data     = m_valid ? mem_q[rptr_q] : '0;
  assign bus.o_m_last     = m_valid && (pkt_q == PKT_MAX);
  assign bus.o_occupancy  = count_q;

endmodule
